// File: rtl/decoder_pkg.sv
// Shared decoder constants and the one-hot pattern helper, also used by the
// plain combinational decoder elsewhere in the display tree.
package decoder_pkg;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_N = 2 ** MAX_SEL_W;

    // 74x138-style enable group: G2A and G2B low, G1 high.
    localparam logic [2:0] EN_MASK  = 3'b111;
    localparam logic [2:0] EN_VALUE = 3'b100;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Callers keep the low 2**SEL_W bits of the result.
    function automatic logic [MAX_OUT_N-1:0] onehot_dec(
        input logic [MAX_SEL_W-1:0] idx,
        input logic                 active_low
    );
        logic [MAX_OUT_N-1:0] pattern;
        pattern      = '0;
        pattern[idx] = 1'b1;
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Control and output bundle of the scanning decoder; the slave side is the
// decoder itself.
interface decoder_scan_if #(
    parameter int SEL_W = 3,
    parameter int DIV_W = 16
) ();

    localparam int OUT_N = 2 ** SEL_W;

    logic [2:0]       en_in;
    logic             mode;
    logic [SEL_W-1:0] data_in;
    logic [DIV_W-1:0] scan_div;
    logic [SEL_W-1:0] scan_last;
    logic [OUT_N-1:0] data_out;
    logic [SEL_W-1:0] sel_out;
    logic             scan_tick;

    modport master (
        output en_in, mode, data_in, scan_div, scan_last,
        input  data_out, sel_out, scan_tick
    );

    modport slave (
        input  en_in, mode, data_in, scan_div, scan_last,
        output data_out, sel_out, scan_tick
    );

endinterface

// File: rtl/decoder_scan_prescaler.sv
// Free-running prescaler that counts 0..div and flags the last count while
// running; clear wins over run.
module scan_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // Equality compare: lowering div below count lets it wrap through 2**DIV_W.
    assign tick = run && (count == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            if (count == div) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered 1-of-2**SEL_W decoder with enable group, direct decode and an
// auto-scan mode that steps the active line across 0..scan_last.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DIV_W      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    decoder_scan_if.slave  bus
);

    localparam int OUT_N = 2 ** SEL_W;
    localparam logic [OUT_N-1:0] INACTIVE = {OUT_N{ACTIVE_LOW != 0}};

    logic                 enabled;
    logic                 scanning;
    logic                 pre_tick;
    logic [SEL_W-1:0]     index;
    logic [SEL_W-1:0]     next_index;
    logic [SEL_W-1:0]     next_sel;
    logic                 next_tick;
    logic                 next_active;
    logic [MAX_OUT_N-1:0] dec_full;
    logic [OUT_N-1:0]     next_out;
    logic                 unused_dec_bits;

    assign enabled  = (bus.en_in & EN_MASK) == EN_VALUE;
    assign scanning = enabled && (bus.mode == MODE_SCAN);

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!scanning),
        .run   (scanning),
        .div   (bus.scan_div),
        .tick  (pre_tick)
    );

    // Disabled beats mode; the index only moves in scan mode, on a prescaler tick.
    always_comb begin
        next_index  = '0;
        next_sel    = '0;
        next_tick   = 1'b0;
        next_active = 1'b0;
        if (enabled) begin
            next_active = 1'b1;
            if (bus.mode == MODE_DIRECT) begin
                next_sel = bus.data_in;
            end else begin
                next_index = index;
                if (pre_tick) begin
                    next_tick  = 1'b1;
                    next_index = (index >= bus.scan_last) ? '0 : index + 1'b1;
                end
                next_sel = next_index;
            end
        end
    end

    assign dec_full        = onehot_dec(MAX_SEL_W'(next_sel), ACTIVE_LOW != 0);
    assign next_out        = next_active ? dec_full[OUT_N-1:0] : INACTIVE;
    assign unused_dec_bits = ^dec_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index         <= '0;
            bus.sel_out   <= '0;
            bus.scan_tick <= 1'b0;
            bus.data_out  <= INACTIVE;
        end else begin
            index         <= next_index;
            bus.sel_out   <= next_sel;
            bus.scan_tick <= next_tick;
            bus.data_out  <= next_out;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: an active-low and an active-high copy
// share stimulus; a cycle model predicts every registered output.
module tb_decoder_scan;

    localparam int SEL_W = 3;
    localparam int DIV_W = 16;

    typedef struct {
        logic [7:0] data_out;
        logic [2:0] sel_out;
        logic       scan_tick;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;
    exp_t sb_q[$];

    int unsigned m_pre;
    int unsigned m_idx;

    decoder_scan_if #(.SEL_W(SEL_W), .DIV_W(DIV_W)) bus ();
    decoder_scan_if #(.SEL_W(SEL_W), .DIV_W(DIV_W)) bus_hi ();

    assign bus_hi.en_in     = bus.en_in;
    assign bus_hi.mode      = bus.mode;
    assign bus_hi.data_in   = bus.data_in;
    assign bus_hi.scan_div  = bus.scan_div;
    assign bus_hi.scan_last = bus.scan_last;

    decoder_scan #(.SEL_W(SEL_W), .DIV_W(DIV_W), .ACTIVE_LOW(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    decoder_scan #(.SEL_W(SEL_W), .DIV_W(DIV_W), .ACTIVE_LOW(0)) dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check_output({tag, " data_out"},    {24'h0, bus.data_out},    {24'h0, e.data_out});
        check_output({tag, " sel_out"},     {29'h0, bus.sel_out},     {29'h0, e.sel_out});
        check_output({tag, " scan_tick"},   {31'h0, bus.scan_tick},   {31'h0, e.scan_tick});
        check_output({tag, " hi data_out"}, {24'h0, bus_hi.data_out}, {24'h0, ~e.data_out});
        check_output({tag, " hi sel_out"},  {29'h0, bus_hi.sel_out},  {29'h0, e.sel_out});
    endtask

    // Drive one cycle of inputs, predict the outputs after the next edge,
    // then pop and compare once the DUT has registered them.
    task automatic apply_stimulus(input string tag, input logic [2:0] en,
                                  input logic md, input logic [2:0] din,
                                  input logic [15:0] div, input logic [2:0] last);
        exp_t e;
        exp_t got;
        bus.en_in     = en;
        bus.mode      = md;
        bus.data_in   = din;
        bus.scan_div  = div;
        bus.scan_last = last;
        e.scan_tick = 1'b0;
        if (en != 3'b100) begin
            m_pre = 0;
            m_idx = 0;
            e.sel_out  = 3'd0;
            e.data_out = 8'hFF;
        end else if (!md) begin
            m_pre = 0;
            m_idx = 0;
            e.sel_out  = din;
            e.data_out = ~(8'h01 << din);
        end else begin
            if (m_pre == int'(div)) begin
                m_pre = 0;
                m_idx = (m_idx >= int'(last)) ? 0 : m_idx + 1;
                e.scan_tick = 1'b1;
            end else begin
                m_pre = m_pre + 1;
            end
            e.sel_out  = 3'(m_idx);
            e.data_out = ~(8'h01 << m_idx);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_all(tag, got);
    endtask

    initial begin
        exp_t rst_exp;
        tests  = 0;
        failed = 0;
        m_pre  = 0;
        m_idx  = 0;
        rst_n  = 1'b0;
        bus.en_in     = 3'b000;
        bus.mode      = 1'b0;
        bus.data_in   = 3'd0;
        bus.scan_div  = 16'd0;
        bus.scan_last = 3'd0;
        rst_exp.data_out  = 8'hFF;
        rst_exp.sel_out   = 3'd0;
        rst_exp.scan_tick = 1'b0;

        #12;
        check_all("reset", rst_exp);
        rst_n = 1'b1;

        apply_stimulus("direct5", 3'b100, 1'b0, 3'd5, 16'd3, 3'd7);
        check_output("direct5 literal", {24'h0, bus.data_out}, 32'hDF);
        apply_stimulus("dis_en0", 3'b101, 1'b0, 3'd3, 16'd3, 3'd7);
        apply_stimulus("direct2", 3'b100, 1'b0, 3'd2, 16'd3, 3'd7);
        apply_stimulus("dis_000", 3'b000, 1'b0, 3'd6, 16'd3, 3'd7);
        check_output("dis hi literal", {24'h0, bus_hi.data_out}, 32'h00);
        apply_stimulus("dis_en1", 3'b110, 1'b1, 3'd6, 16'd3, 3'd7);
        apply_stimulus("direct0", 3'b100, 1'b0, 3'd0, 16'd3, 3'd7);
        check_output("direct0 hi literal", {24'h0, bus_hi.data_out}, 32'h01);
        apply_stimulus("direct7", 3'b100, 1'b0, 3'd7, 16'd3, 3'd7);

        for (int i = 0; i < 36; i++)
            apply_stimulus("scan_d3", 3'b100, 1'b1, 3'd5, 16'd3, 3'd7);

        apply_stimulus("direct_clr", 3'b100, 1'b0, 3'd1, 16'd0, 3'd2);
        for (int i = 0; i < 5; i++)
            apply_stimulus("scan_d0", 3'b100, 1'b1, 3'd1, 16'd0, 3'd2);
        for (int i = 0; i < 4; i++)
            apply_stimulus("scan_last0", 3'b100, 1'b1, 3'd1, 16'd0, 3'd0);
        check_output("scan_last0 idx", {29'h0, bus.sel_out}, 32'd0);

        apply_stimulus("direct_pre", 3'b100, 1'b0, 3'd3, 16'd5, 3'd7);
        for (int i = 0; i < 100 && m_idx != 4; i++)
            apply_stimulus("scan_to4", 3'b100, 1'b1, 3'd3, 16'd5, 3'd7);
        check_output("reached idx4", {29'h0, bus.sel_out}, 32'd4);

        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", rst_exp);
        #1;
        rst_n = 1'b1;
        m_pre = 0;
        m_idx = 0;
        for (int i = 0; i < 14; i++)
            apply_stimulus("scan_after_rst", 3'b100, 1'b1, 3'd3, 16'd5, 3'd7);

        apply_stimulus("back_direct", 3'b100, 1'b0, 3'd6, 16'd5, 3'd7);
        apply_stimulus("final_dis", 3'b001, 1'b1, 3'd6, 16'd5, 3'd7);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
